imem_program_loader: RTL
========================

Name: imem_program_loader

Overview:
- Sequential instruction encoder/writer: the encode side of the processor's opcode decoder.
- Accepts symbolic instruction beats (kind, registers, immediate, target) over a valid/ready handshake, assembles 32-bit instruction words using the processor's exact opcode map, and writes them into instruction memory at consecutive word addresses.
- Sits between the testbench/boot host and the instruction memory write port. Used to load programs before the CPU is released.

Parameters:
- ADDR_W, 8, width of the byte address driven to instruction memory.
- DEPTH, 64, maximum number of words per load; DEPTH*4 must be at most 2^ADDR_W.
- BASE_ADDR, 0, byte address of the first word written; must be word aligned.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  instruction beat valid.
- in_ready  out  1  loader can accept a beat.
- in_last  in  1  beat is the final instruction of the program.
- op_kind  in  4  0 R, 1 ADDI, 2 SLTI, 3 LW, 4 SW, 5 J, 6 JAL, 7 JR, 8 BEQ; 9..15 invalid.
- alu_op  in  3  R-type ALU operation.
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  immediate / branch offset.
- target  in  26  jump target field.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  byte write address.
- imem_wdata  out  32  encoded instruction word.
- word_count  out  $clog2(DEPTH+1)  words written since last start.
- done  out  1  load completed.
- err  out  1  load aborted.
- err_code  out  2  00 none, 01 BADOP, 10 FULL.

Behaviour:
Reset:
- Reset is synchronous and active-high on rst; clock is clk.
- rst forces: state IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, word_count=0, done=0, err=0, err_code=00.
- rst mid-load discards any latched beat. No write is issued in the reset cycle.

Encoding (registered at accept):
- R: {000000, rs, rt, rd, 00000, 100, alu_op}.
- ADDI / SLTI / LW / SW / BEQ: {opcode, rs, rt, imm}, with opcodes 001000 / 001010 / 100011 / 101011 / 111000.
- J / JAL: {000010 / 000011, target}.
- JR: {000100, rs, 21'b0}.
- Fields are inserted bit-exact. There is no sign extension or alteration.

FSM:
- IDLE: in_ready=0. start -> LOAD; clear imem_addr to BASE_ADDR, word_count to 0, done, err and err_code.
- LOAD: in_ready=1. On in_valid & in_ready:
  - invalid op_kind -> ERR, err_code=01, no write.
  - otherwise latch the encoded word and in_last -> WRITE.
- WRITE: in_ready=0 and imem_we=1 for exactly one cycle, with the current imem_addr and imem_wdata. At the end of the cycle, imem_addr+=4 and word_count+=1. Next state:
  - latched last=1 -> DONE.
  - else word_count+1==DEPTH -> ERR, err_code=10.
  - else LOAD.
- DONE: done=1 held; in_ready=0. start -> LOAD, with the same clears as from IDLE.
- ERR: err=1 held; in_ready=0. start -> LOAD, with the same clears.

Timing and handshake rules:
- start is ignored in LOAD and WRITE.
- Latency: accept edge to imem_we is 1 cycle. Peak throughput is 1 word per 2 cycles.
- The last beat of a program exactly at DEPTH words -> DONE, not ERR.
- imem_wdata holds its last value outside WRITE; imem_we is 0 outside WRITE.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- When defined, an extra output checksum [31:0] is present. It is the running XOR of every word written. It is cleared by rst and by an honoured start, updates on the WRITE edge, and is stable while DONE.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package loader_pkg holds:
  - the op_kind enum;
  - the 6-bit opcode constants, shared with the controller's decode map;
  - the R-type funct prefix 3'b100;
  - the err_code constants;
  - the FSM state enum.
- One sub-module, instr_encoder: combinational mapping from fields to the 32-bit word plus a bad_op flag. imem_program_loader holds the FSM, address counter and output registers.

Test Plan:
- R add (rs=1, rt=2, rd=3, alu_op=0, last=1) after start -> one write, addr 0x00, data 0x00221820; done=1; word_count=1.
- Sequence LW (rs=0, rt=8, imm=0x0010), BEQ (rs=1, rt=2, imm=0xFFFF), J (target 0x40), JAL (target 0x40), JR (rs=31, last) -> writes to 0x00/0x04/0x08/0x0C/0x10 with data 0x8C080010, 0xE022FFFF, 0x08000040, 0x0C000040, 0x13E00000.
- op_kind=9 at beat 2 -> only 1 write; err=1, err_code=01; in_ready=0; a subsequent start -> LOAD, addr 0x00, err cleared.
- DEPTH=4, five non-last beats -> four writes (0x00..0x0C), then err_code=10; the fifth beat is never accepted. With DEPTH=4, four beats where the fourth is last -> done=1, no error.
- rst asserted during WRITE, and in_valid held with in_ready low -> imem_we=0 in the rst cycle and after; all outputs at reset values. A beat is only consumed when in_ready=1.
- LOADER_CHECKSUM_EN defined, words 0x00221820 and 0x8C080010 -> checksum 0x8C2A1830; a new start clears it to 0.

Source files
------------

// File: rtl/imem_program_loader_pkg.sv
// Shared encode-side definitions for the instruction loader: op kinds, the
// processor opcode map, R-type funct prefix, error codes and loader states.
package loader_pkg;

   typedef enum logic [3:0] {
      OPK_R    = 4'd0,
      OPK_ADDI = 4'd1,
      OPK_SLTI = 4'd2,
      OPK_LW   = 4'd3,
      OPK_SW   = 4'd4,
      OPK_J    = 4'd5,
      OPK_JAL  = 4'd6,
      OPK_JR   = 4'd7,
      OPK_BEQ  = 4'd8
   } op_kind_e;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_SLTI  = 6'b001010;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b111000;
   localparam logic [5:0] OPC_J     = 6'b000010;
   localparam logic [5:0] OPC_JAL   = 6'b000011;
   localparam logic [5:0] OPC_JR    = 6'b000100;

   localparam logic [2:0] FUNCT_R_PREFIX = 3'b100;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_BADOP = 2'b01;
   localparam logic [1:0] ERR_FULL  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_e;

   function automatic logic [31:0] enc_itype(input logic [5:0] opc, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

endpackage

// File: rtl/imem_program_loader_encoder.sv
// instr_encoder: combinational field-to-word mapping using the processor opcode map.
module instr_encoder
   import loader_pkg::*;
(
   input  logic [3:0]  op_kind_i,
   input  logic [2:0]  alu_op_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [15:0] imm_i,
   input  logic [25:0] target_i,
   output logic [31:0] word_o,
   output logic        bad_op_o
);

   // Fields are inserted bit-exact; no sign extension anywhere.
   always_comb begin
      word_o   = 32'h0000_0000;
      bad_op_o = 1'b0;
      case (op_kind_i)
         OPK_R:    word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'b00000, FUNCT_R_PREFIX, alu_op_i};
         OPK_ADDI: word_o = enc_itype(OPC_ADDI, rs_i, rt_i, imm_i);
         OPK_SLTI: word_o = enc_itype(OPC_SLTI, rs_i, rt_i, imm_i);
         OPK_LW:   word_o = enc_itype(OPC_LW, rs_i, rt_i, imm_i);
         OPK_SW:   word_o = enc_itype(OPC_SW, rs_i, rt_i, imm_i);
         OPK_BEQ:  word_o = enc_itype(OPC_BEQ, rs_i, rt_i, imm_i);
         OPK_J:    word_o = {OPC_J, target_i};
         OPK_JAL:  word_o = {OPC_JAL, target_i};
         OPK_JR:   word_o = {OPC_JR, rs_i, 21'b0};
         default:  bad_op_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/imem_program_loader.sv
// Program loader: encodes instruction beats and writes them to consecutive imem words.
// Optional LOADER_CHECKSUM_EN adds a running XOR checksum output of written words.
module imem_program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 64,
   parameter int BASE_ADDR = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_last,
   input  logic [3:0]                   op_kind,
   input  logic [2:0]                   alu_op,
   input  logic [4:0]                   rs,
   input  logic [4:0]                   rt,
   input  logic [4:0]                   rd,
   input  logic [15:0]                  imm,
   input  logic [25:0]                  target,
   output logic                         imem_we,
   output logic [ADDR_W-1:0]            imem_addr,
   output logic [31:0]                  imem_wdata,
   output logic [$clog2(DEPTH+1)-1:0]   word_count,
   output logic                         done,
   output logic                         err,
`ifdef LOADER_CHECKSUM_EN
   output logic [31:0]                  checksum,
`endif
   output logic [1:0]                   err_code
);

   localparam int                  WC_W    = $clog2(DEPTH+1);
   localparam logic [WC_W-1:0]     DEPTH_C = WC_W'(DEPTH);
   localparam logic [ADDR_W-1:0]   BASE_C  = ADDR_W'(BASE_ADDR);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [WC_W-1:0]     wc_q, wc_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [1:0]          code_q, code_d;
   logic                we_q, we_d;
   logic                rdy_q, rdy_d;
   logic                last_q, last_d;
   logic [31:0]         csum_q, csum_d;
   logic [31:0]         enc_word_s;
   logic                bad_op_s;

   instr_encoder u_enc (
      .op_kind_i (op_kind),
      .alu_op_i  (alu_op),
      .rs_i      (rs),
      .rt_i      (rt),
      .rd_i      (rd),
      .imm_i     (imm),
      .target_i  (target),
      .word_o    (enc_word_s),
      .bad_op_o  (bad_op_s)
   );

   // Next-state and output-register logic for the load FSM.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wc_d    = wc_q;
      done_d  = done_q;
      err_d   = err_q;
      code_d  = code_q;
      last_d  = last_q;
      csum_d  = csum_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LOAD;
               addr_d  = BASE_C;
               wc_d    = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               code_d  = ERR_NONE;
               csum_d  = 32'h0000_0000;
            end else begin
               state_d = state_q;
            end
         end
         S_LOAD: begin
            if (in_valid && rdy_q) begin
               if (bad_op_s) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
                  code_d  = ERR_BADOP;
               end else begin
                  state_d = S_WRITE;
                  wdata_d = enc_word_s;
                  last_d  = in_last;
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_WRITE: begin
            addr_d = addr_q + ADDR_W'(4);
            wc_d   = wc_q + WC_W'(1);
            csum_d = csum_q ^ wdata_q;
            if (last_q) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (wc_q + WC_W'(1) == DEPTH_C) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               code_d  = ERR_FULL;
            end else begin
               state_d = S_LOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
      we_d  = (state_d == S_WRITE);
      rdy_d = (state_d == S_LOAD);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= BASE_C;
         wdata_q <= 32'h0000_0000;
         wc_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         we_q    <= 1'b0;
         rdy_q   <= 1'b0;
         last_q  <= 1'b0;
         csum_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wc_q    <= wc_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
         we_q    <= we_d;
         rdy_q   <= rdy_d;
         last_q  <= last_d;
         csum_q  <= csum_d;
      end
   end

   // The strobe is masked by rst so memory never sees a write in a reset cycle.
   assign imem_we    = we_q & ~rst;
   assign in_ready   = rdy_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign word_count = wc_q;
   assign done       = done_q;
   assign err        = err_q;
   assign err_code   = code_q;
`ifdef LOADER_CHECKSUM_EN
   assign checksum   = csum_q;
`endif

endmodule
